// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU: operation codes and controller states.
package alu_pkg;

   typedef enum logic [1:0] {OP_AND, OP_OR, OP_ADD, OP_XOR} alu_op_t;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} alu_state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: per-bit operand inversion, then AND/OR/ADD/XOR.
// The carry out is always the full-adder carry, whatever the op.
module alu_bit_slice
   import alu_pkg::*;
(
   input  logic    a,
   input  logic    b,
   input  logic    a_inv,
   input  logic    b_inv,
   input  logic    ci,
   input  alu_op_t op,
   output logic    x,
   output logic    co
);

   logic ai;
   logic bi;

   assign ai = a ^ a_inv;
   assign bi = b ^ b_inv;
   assign co = (ai & bi) | (ci & (ai ^ bi));

   always_comb begin
      x = 1'b0;
      case (op)
         OP_AND:  x = ai & bi;
         OP_OR:   x = ai | bi;
         OP_ADD:  x = ai ^ bi ^ ci;
         OP_XOR:  x = ai ^ bi;
         default: x = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial WIDTH-bit ALU: one bit per clock through a single alu_bit_slice.
// Optional FLAGS_EN macro adds registered zero/neg/ovf flags; otherwise they read 0.
module alu_serial
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             a_inv,
   input  logic             b_inv,
   input  logic             c_in,
   input  logic [1:0]       op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] x,
   output logic             c_out,
   output logic             zero,
   output logic             neg,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);

   alu_state_t       state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, x_q, x_shift;
   logic [CW-1:0]    cnt_q;
   alu_op_t          op_q;
   logic             a_inv_q, b_inv_q, carry_q, c_out_q;
   logic             s_x, s_co;
   logic             accept, last;

   // Start is honoured only when no operation is in flight.
   assign accept  = start && (state_q == S_IDLE || state_q == S_DONE);
   assign last    = (state_q == S_RUN) && (cnt_q == CW'(WIDTH - 1));
   assign x_shift = {s_x, x_q[WIDTH-1:1]};

   alu_bit_slice u_slice (
      .a     (a_q[0]),
      .b     (b_q[0]),
      .a_inv (a_inv_q),
      .b_inv (b_inv_q),
      .ci    (carry_q),
      .op    (op_q),
      .x     (s_x),
      .co    (s_co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last) state_d = S_DONE;
         S_DONE:  state_d = start ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == S_RUN);
      done = (state_q == S_DONE);
   end

   // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at x[0].
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         x_q     <= '0;
         cnt_q   <= '0;
         op_q    <= OP_AND;
         a_inv_q <= 1'b0;
         b_inv_q <= 1'b0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b;
         op_q    <= alu_op_t'(op);
         a_inv_q <= a_inv;
         b_inv_q <= b_inv;
         carry_q <= c_in;
         cnt_q   <= '0;
      end else if (state_q == S_RUN) begin
         a_q     <= a_q >> 1;
         b_q     <= b_q >> 1;
         x_q     <= x_shift;
         carry_q <= s_co;
         cnt_q   <= cnt_q + CW'(1);
         if (last) c_out_q <= s_co;
      end
   end

   assign x     = x_q;
   assign c_out = c_out_q;

`ifdef FLAGS_EN
   logic zero_q, neg_q, ovf_q;

   // carry_q still holds the carry into the MSB during the last RUN cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (last) begin
         zero_q <= (x_shift == '0);
         neg_q  <= s_x;
         ovf_q  <= (op_q == OP_ADD) && (carry_q ^ s_co);
      end
   end

   assign zero = zero_q;
   assign neg  = neg_q;
   assign ovf  = ovf_q;
`else
   assign zero = 1'b0;
   assign neg  = 1'b0;
   assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial (WIDTH=8): directed vector table, randomized ops against
// an arithmetic reference model, and multi-cycle sequences for start/reset corners.
module tb_alu_serial;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, start, a_inv, b_inv, c_in;
   logic [W-1:0] a, b;
   logic [1:0]   op;
   logic         busy, done, c_out, zero, neg, ovf;
   logic [W-1:0] x;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] x;
      logic         c, z, n, o;
   } res_t;

   typedef struct {
      logic [W-1:0] a, b;
      logic         ai, bi, ci;
      logic [1:0]   op;
      res_t         exp;
   } vec_t;

   logic [W-1:0] exp_q[$];
   vec_t         tbl[9];

   alu_serial #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .a_inv(a_inv), .b_inv(b_inv), .c_in(c_in), .op(op),
      .busy(busy), .done(done), .x(x), .c_out(c_out),
      .zero(zero), .neg(neg), .ovf(ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic vai, input logic vbi, input logic vci,
                               input logic [1:0] vop, input logic [W-1:0] ex,
                               input logic ec, input logic ez, input logic en, input logic eo);
      vec_t v;
      v.a = va; v.b = vb; v.ai = vai; v.bi = vbi; v.ci = vci; v.op = vop;
      v.exp.x = ex; v.exp.c = ec; v.exp.z = ez; v.exp.n = en; v.exp.o = eo;
      return v;
   endfunction

   // Whole-word reference: invert, add with carry, pick the op result.
   function automatic res_t model(input vec_t v);
      res_t         r;
      logic [W-1:0] aa, bb;
      logic [W:0]   sum;
      aa  = v.ai ? ~v.a : v.a;
      bb  = v.bi ? ~v.b : v.b;
      sum = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, v.ci};
      case (v.op)
         2'd0:    r.x = aa & bb;
         2'd1:    r.x = aa | bb;
         2'd2:    r.x = sum[W-1:0];
         default: r.x = aa ^ bb;
      endcase
      r.c = sum[W];
      r.z = (r.x == '0);
      r.n = r.x[W-1];
      r.o = (v.op == 2'd2) && (aa[W-1] == bb[W-1]) && (r.x[W-1] != aa[W-1]);
      return r;
   endfunction

   task automatic drive(input vec_t v);
      a = v.a; b = v.b; a_inv = v.ai; b_inv = v.bi; c_in = v.ci; op = v.op;
   endtask

   task automatic check_result(input string tag, input res_t e);
      logic fz, fn, fo;
`ifdef FLAGS_EN
      fz = e.z; fn = e.n; fo = e.o;
`else
      fz = 1'b0; fn = 1'b0; fo = 1'b0;
`endif
      chk({tag, ".x"}, 32'(x), 32'(e.x));
      chk({tag, ".c_out"}, 32'(c_out), 32'(e.c));
      chk({tag, ".zero"}, 32'(zero), 32'(fz));
      chk({tag, ".neg"}, 32'(neg), 32'(fn));
      chk({tag, ".ovf"}, 32'(ovf), 32'(fo));
   endtask

   task automatic run_op(input vec_t v, input res_t e, input string tag);
      int           cyc;
      logic [W-1:0] held;
      @(negedge clk);
      drive(v);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); op = 2'($urandom_range(0, 3));
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      cyc = 1;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, ".latency"}, 32'(cyc), 32'(W + 1));
      check_result(tag, e);
      held = x;
      @(negedge clk);
      chk({tag, ".done_drop"}, 32'(done), 32'd0);
      chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
      chk({tag, ".x_hold"}, 32'(x), 32'(held));
   endtask

   initial begin
      vec_t         v, bq[3];
      res_t         e;
      int           dones, when, pulses, last_c;
      logic [W-1:0] got_x;
      logic         got_c;

      tbl[0] = mk(8'h7F, 8'h01, 0, 0, 0, 2'd2, 8'h80, 0, 0, 1, 1);
      tbl[1] = mk(8'h05, 8'h07, 0, 1, 1, 2'd2, 8'hFE, 0, 0, 1, 0);
      tbl[2] = mk(8'hF0, 8'h3C, 0, 0, 0, 2'd0, 8'h30, 1, 0, 0, 0);
      tbl[3] = mk(8'hF0, 8'h3C, 0, 0, 0, 2'd1, 8'hFC, 1, 0, 1, 0);
      tbl[4] = mk(8'hF0, 8'h3C, 0, 0, 0, 2'd3, 8'hCC, 1, 0, 1, 0);
      tbl[5] = mk(8'hF0, 8'h3C, 1, 0, 0, 2'd0, 8'h0C, 0, 0, 0, 0);
      tbl[6] = mk(8'hFF, 8'h01, 0, 0, 0, 2'd2, 8'h00, 1, 1, 0, 0);
      tbl[7] = mk(8'h80, 8'h80, 0, 0, 0, 2'd2, 8'h00, 1, 1, 0, 1);
      tbl[8] = mk(8'hAA, 8'h55, 1, 1, 1, 2'd3, 8'hFF, 1, 0, 1, 0);

      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      a_inv = 1'b0; b_inv = 1'b0; c_in = 1'b0; op = 2'd0;
      repeat (2) @(negedge clk);
      chk("reset.busy", 32'(busy), 32'd0);
      chk("reset.done", 32'(done), 32'd0);
      e.x = '0; e.c = 1'b0; e.z = 1'b0; e.n = 1'b0; e.o = 1'b0;
      check_result("reset", e);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) run_op(tbl[i], tbl[i].exp, $sformatf("vec%0d", i));

      for (int i = 0; i < 40; i++) begin
         v.a = W'($urandom); v.b = W'($urandom);
         v.ai = 1'($urandom_range(0, 1)); v.bi = 1'($urandom_range(0, 1));
         v.ci = 1'($urandom_range(0, 1)); v.op = 2'($urandom_range(0, 3));
         run_op(v, model(v), $sformatf("rnd%0d", i));
      end

      // Starts during RUN must be ignored.
      @(negedge clk);
      drive(tbl[0]);
      start = 1'b1;
      dones = 0; when = 0; got_x = '0; got_c = 1'b0;
      @(negedge clk);
      for (int c = 1; c <= 20; c++) begin
         if (done) begin
            dones++; when = c; got_x = x; got_c = c_out;
         end
         start = (c == 3 || c == 5);
         if (start) begin
            a = 8'h12; b = 8'h34; op = 2'd3;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("ignore.dones", 32'(dones), 32'd1);
      chk("ignore.when", 32'(when), 32'(W + 1));
      chk("ignore.x", 32'(got_x), 32'h80);
      chk("ignore.c_out", 32'(got_c), 32'd0);

      // Reset four cycles into RUN discards the operation.
      @(negedge clk);
      drive(tbl[3]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst.busy", 32'(busy), 32'd0);
      chk("midrst.done", 32'(done), 32'd0);
      chk("midrst.x", 32'(x), 32'd0);
      chk("midrst.c_out", 32'(c_out), 32'd0);
      rst = 1'b0;
      run_op(tbl[1], tbl[1].exp, "after_rst");

      // Back-to-back with start held high through DONE.
      bq[0] = tbl[2]; bq[1] = tbl[6]; bq[2] = tbl[8];
      for (int i = 0; i < 3; i++) exp_q.push_back(model(bq[i]).x);
      @(negedge clk);
      drive(bq[0]);
      start = 1'b1;
      pulses = 0; last_c = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (pulses > 0 && pulses < 3 && c == last_c + 1)
            chk("b2b.no_idle", 32'(busy), 32'd1);
         if (done) begin
            chk("b2b.interval", 32'(c - last_c), 32'(W + 1));
            if (exp_q.size() > 0) chk("b2b.x", 32'(x), 32'(exp_q.pop_front()));
            if (pulses < 3) check_result("b2b", model(bq[pulses]));
            last_c = c;
            pulses++;
            if (pulses < 3) drive(bq[pulses]);
            else start = 1'b0;
         end
      end
      start = 1'b0;
      chk("b2b.pulses", 32'(pulses), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
